// File: rtl/usb_token_ctrl_if.sv
// Purpose : byte-receiver, CRC5-engine and protocol-layer signals of the USB token sequencer.
// Ports   : rx_* from the byte receiver, crc_* to/from the shared CRC5 engine, tok_*/busy to the protocol layer.
// Modports: slave = the sequencer itself, master = whatever drives and consumes it.
interface usb_token_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_byte_valid;
  logic       rx_eop;
  logic       rx_abort;
  logic       crc_rem_ok;
  logic       crc_clear;
  logic       crc_shift_en;
  logic       crc_bit;
  logic       tok_valid;
  logic       tok_error;
  logic [3:0] tok_pid;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       busy;

  modport slave (
    input  rx_data, rx_byte_valid, rx_eop, rx_abort, crc_rem_ok,
    output crc_clear, crc_shift_en, crc_bit,
    output tok_valid, tok_error, tok_pid, tok_addr, tok_endp, busy
  );

  modport master (
    output rx_data, rx_byte_valid, rx_eop, rx_abort, crc_rem_ok,
    input  crc_clear, crc_shift_en, crc_bit,
    input  tok_valid, tok_error, tok_pid, tok_addr, tok_endp, busy
  );
endinterface

// File: rtl/usb_token_ctrl.sv
// Purpose : collects PID + two token bytes, streams the 16 token bits LSB-first into the CRC5 engine,
//           checks the residue and reports a decoded token or an error.
// Latency : tok_valid/tok_error 18 cycles after byte2 when EOP lands during the shift, else 2 cycles after rx_eop;
//           rx_abort raises tok_error in the same cycle.
// Backpressure: none; the receiver cannot be stalled, so late/extra/missing bytes are flagged as errors.
// Ports   : clk, n_rst (async active-low); bus (slave modport) carries rx_*, crc_* and tok_*/busy.
module usb_token_ctrl #(
  parameter int BYTE_TIMEOUT = 64,
  parameter int TO_W         = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  usb_token_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, GET_B1, GET_B2, SHIFT, WAIT_EOP, CHECK} state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BYTE_TIMEOUT);

  state_t          state;
  logic [15:0]     sreg;
  logic [3:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            eop_seen;
  logic            len_err;
  logic            pid_ok;
  logic [3:0]      pid_q;
  logic            tok_valid_q;
  logic            tok_error_q;
  logic            crc_clear_q;
  logic [3:0]      tok_pid_q;
  logic [6:0]      tok_addr_q;
  logic [3:0]      tok_endp_q;

  logic timeout;
  logic abort_now;

  // to_cnt holds the idle cycles seen so far; a byte is still accepted after exactly BYTE_TIMEOUT of them.
  assign timeout   = (to_cnt > TO_LIMIT);
  assign abort_now = bus.rx_abort && (state != IDLE);

  function automatic logic pid_valid(input logic [7:0] b);
    return (b[7:4] == ~b[3:0]) &&
           ((b[3:0] == 4'b0001) || (b[3:0] == 4'b1001) ||
            (b[3:0] == 4'b1101) || (b[3:0] == 4'b0101));
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      sreg        <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      eop_seen    <= 1'b0;
      len_err     <= 1'b0;
      pid_ok      <= 1'b0;
      pid_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_error_q <= 1'b0;
      crc_clear_q <= 1'b0;
      tok_pid_q   <= '0;
      tok_addr_q  <= '0;
      tok_endp_q  <= '0;
    end else begin
      tok_valid_q <= 1'b0;
      tok_error_q <= 1'b0;
      crc_clear_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_byte_valid) begin
            pid_q       <= bus.rx_data[3:0];
            pid_ok      <= pid_valid(bus.rx_data);
            crc_clear_q <= 1'b1;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            eop_seen    <= 1'b0;
            len_err     <= 1'b0;
            state       <= GET_B1;
          end
        end
        GET_B1, GET_B2: begin
          if (bus.rx_abort) begin
            state <= IDLE;               // error pulse is driven combinationally
          end else if (timeout || bus.rx_eop) begin
            tok_error_q <= 1'b1;
            state       <= IDLE;
          end else if (bus.rx_byte_valid) begin
            to_cnt <= '0;
            if (state == GET_B1) begin
              sreg[7:0] <= bus.rx_data;
              state     <= GET_B2;
            end else begin
              sreg[15:8] <= bus.rx_data;
              bit_cnt    <= '0;
              state      <= SHIFT;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        SHIFT: begin
          if (bus.rx_abort) begin
            state <= IDLE;
          end else begin
            if (bus.rx_eop)             eop_seen <= 1'b1;
            else if (bus.rx_byte_valid) len_err  <= 1'b1;
            // counter keeps running so the EOP deadline is measured from byte2
            to_cnt  <= to_cnt + TO_W'(1);
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15)
              state <= (eop_seen || bus.rx_eop) ? CHECK : WAIT_EOP;
          end
        end
        WAIT_EOP: begin
          if (bus.rx_abort) begin
            state <= IDLE;
          end else if (timeout) begin
            tok_error_q <= 1'b1;
            state       <= IDLE;
          end else if (bus.rx_eop) begin
            state <= CHECK;
          end else begin
            if (bus.rx_byte_valid) len_err <= 1'b1;
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          // crc_rem_ok is stable here: the last shift was at least one cycle ago
          state <= IDLE;
          if (!bus.rx_abort) begin
            if (pid_ok && bus.crc_rem_ok && !len_err) begin
              tok_valid_q <= 1'b1;
              tok_pid_q   <= pid_q;
              tok_addr_q  <= sreg[6:0];
              tok_endp_q  <= sreg[10:7];
            end else begin
              tok_error_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Abort must silence the engine and flag the error in the cycle it is seen.
  assign bus.crc_shift_en = (state == SHIFT) && !bus.rx_abort;
  assign bus.crc_bit      = (state == SHIFT) && sreg[bit_cnt];
  assign bus.crc_clear    = crc_clear_q;
  assign bus.tok_valid    = tok_valid_q;
  assign bus.tok_error    = tok_error_q || abort_now;
  assign bus.tok_pid      = tok_pid_q;
  assign bus.tok_addr     = tok_addr_q;
  assign bus.tok_endp     = tok_endp_q;
  assign bus.busy         = (state != IDLE);

endmodule
